hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It sits beside the forwarding unit and drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It handles three cases:
- load-use stalls that forwarding cannot cover;
- taken-branch flushes resolved in ID;
- multi-cycle data-memory waits, with a timeout watchdog.

## Interface

Parameters:
- TIMEOUT, 64: maximum consecutive data-memory wait cycles before error. 0 disables the watchdog; otherwise it must be ≥2.
- CNT_W, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- ID_RS_i  in  5  rs of the instruction in ID
- ID_RT_i  in  5  rt of the instruction in ID
- ID_EX_memread_i  in  1  instruction in EX is a load
- ID_EX_RT_i  in  5  destination of the load in EX
- branch_taken_i  in  1  branch in ID resolved taken
- mem_req_i  in  1  instruction in MEM accesses data memory
- mem_ack_i  in  1  data memory completes the access this cycle
- PC_write_o  out  1  PC update enable
- IF_ID_write_o  out  1  IF/ID register enable
- IF_flush_o  out  1  IF/ID loads a NOP
- ID_EX_write_o  out  1  ID/EX register enable
- ID_EX_bubble_o  out  1  ID/EX loads a bubble (control bits zero)
- EX_MEM_write_o  out  1  EX/MEM register enable
- MEM_WB_bubble_o  out  1  MEM/WB loads a bubble
- mem_err_o  out  1  sticky watchdog error
- stall_cycles_o  out  CNT_W  cycles spent frozen or load-use stalled
- flush_count_o  out  CNT_W  number of branch flushes

## Operation

- States: RUN, MEM_WAIT, ERR. A wait counter `wcnt` counts consecutive memory-wait cycles.
- Outputs are combinational from the state and the inputs. The state and counters are registered.
- Idle output values: all *_write_o = 1, all bubble/flush = 0, mem_err_o = 0.
- Freeze: PC/IF_ID/ID_EX/EX_MEM write = 0, MEM_WB_bubble_o = 1, IF_flush_o = 0, ID_EX_bubble_o = 0.
- Load-use condition: ID_EX_memread_i & ID_EX_RT_i≠0 & (ID_EX_RT_i==ID_RS_i | ID_EX_RT_i==ID_RT_i).
- Priority in RUN (highest first):
  1. mem_req_i & !mem_ack_i: freeze; next state MEM_WAIT; wcnt←1.
  2. Load-use: PC_write_o = IF_ID_write_o = 0, ID_EX_bubble_o = 1. Any branch flush is suppressed, because the branch operand is stale.
  3. branch_taken_i: IF_flush_o = 1.
  4. Otherwise: idle outputs.
- A request with an ack in the same cycle is not a stall.
- MEM_WAIT, mem_ack_i = 1: evaluate rules 2–4 as in RUN; next state RUN; wcnt←0.
- MEM_WAIT, mem_ack_i = 0: freeze.
  - If TIMEOUT≠0 and wcnt+1==TIMEOUT: next state ERR.
  - Else wcnt←wcnt+1.
- ERR: freeze permanently and mem_err_o = 1. Only rst_i exits this state.
- A branch_taken_i arriving during a freeze is held in ID by the frozen IF/ID and is re-evaluated on release; it is not lost.
- While rst_i is high, all outputs are forced to idle values and counters to 0, whatever the inputs. A reset asserted mid-wait returns to RUN immediately.

## Timing

- Stall, bubble and flush outputs take effect in the same cycle as their causing inputs, with zero latency.
- A load-use stall lasts exactly 1 cycle. On the next cycle ID_EX_memread_i reads the bubble.
- A memory wait of N cycles freezes for N cycles. Release happens in the cycle mem_ack_i is high.
- ERR is entered on the edge that ends the TIMEOUT-th consecutive wait cycle. mem_err_o rises in the following cycle.
- Counters saturate at 2^CNT_W−1. They increment on the edge that ends the qualifying cycle.

## Configuration

- `HAZARD_PERF_CNT_EN` defined: stall_cycles_o counts every freeze or load-use cycle; flush_count_o counts every cycle with IF_flush_o = 1.
- `HAZARD_PERF_CNT_EN` undefined: both ports remain and are tied to 0. No counter flops are synthesized.

## Structure

- Package hazard_pkg holds:
  - the state typedef: RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2;
  - REG_ZERO = 5'd0;
  - the idle and freeze control-vector constants.
- Sub-module load_use_detect: the purely combinational load-use comparator, instantiated once.

## Test plan

- ID_EX_memread_i = 1, ID_EX_RT_i = 8, ID_RS_i = 8 → one cycle with PC_write_o = 0, IF_ID_write_o = 0, ID_EX_bubble_o = 1; then idle. Repeat with ID_EX_RT_i = 0 → no stall.
- branch_taken_i and a load-use hazard on rt in the same cycle → IF_flush_o = 0 and stall asserted; the next cycle has branch_taken_i only → IF_flush_o = 1.
- mem_req_i = 1, mem_ack_i low for 3 cycles then high → freeze for cycles 1–3; cycle 4 idle with state RUN; stall_cycles_o = 3 with the macro defined.
- TIMEOUT = 4, mem_req_i held, no ack → freeze in cycles 1–4; ERR from cycle 5 with mem_err_o = 1; the state persists until rst_i.
- rst_i pulsed asynchronously (not on a clock edge) during MEM_WAIT with wcnt = 2 → outputs idle immediately; state RUN and counters 0 after release.
- mem_req_i and mem_ack_i both 1 in the same cycle → no freeze, stall_cycles_o unchanged.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state type, register-zero constant and pipeline control vectors for hazard_ctrl
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE   = ctrl_t'(7'b1101010);
    // Everything up to EX/MEM holds; MEM/WB takes a bubble so WB does not repeat.
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b0000001);
    // PC and IF/ID hold while a bubble enters EX.
    localparam ctrl_t CTRL_LU     = ctrl_t'(7'b0001110);
    localparam ctrl_t CTRL_FLUSH  = ctrl_t'(7'b1111010);

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational check that a load in EX feeds a source register of the instruction in ID
//   ID_EX_memread_i, ID_EX_RT_i : load in EX and its destination
//   ID_RS_i, ID_RT_i            : sources of the instruction in ID
//   hazard_o                    : a one-cycle stall is required
module load_use_detect
    import hazard_pkg::*;
(
    input  logic       ID_EX_memread_i,
    input  logic [4:0] ID_EX_RT_i,
    input  logic [4:0] ID_RS_i,
    input  logic [4:0] ID_RT_i,
    output logic       hazard_o
);

    assign hazard_o = ID_EX_memread_i && (ID_EX_RT_i != REG_ZERO) &&
                      ((ID_EX_RT_i == ID_RS_i) || (ID_EX_RT_i == ID_RT_i));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and data-memory wait sequencer with watchdog
//   Optional feature macro: HAZARD_PERF_CNT_EN (performance counters; tied to 0 when undefined)
//   clk_i, rst_i (async, active-high)
//   ID_RS_i, ID_RT_i, ID_EX_memread_i, ID_EX_RT_i : load-use inputs
//   branch_taken_i                                : taken branch in ID
//   mem_req_i, mem_ack_i                          : data-memory handshake
//   *_write_o, *_bubble_o, IF_flush_o             : pipeline register controls
//   mem_err_o                                     : sticky watchdog error
//   stall_cycles_o, flush_count_o                 : saturating performance counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_RS_i,
    input  logic [4:0]       ID_RT_i,
    input  logic             ID_EX_memread_i,
    input  logic [4:0]       ID_EX_RT_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             PC_write_o,
    output logic             IF_ID_write_o,
    output logic             IF_flush_o,
    output logic             ID_EX_write_o,
    output logic             ID_EX_bubble_o,
    output logic             EX_MEM_write_o,
    output logic             MEM_WB_bubble_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t          r_state;
    logic [WC_W-1:0] r_wcnt;
    logic            w_lu;
    logic            w_freeze;
    logic            w_tmo;
    ctrl_t           w_resolve;
    ctrl_t           w_ctrl;

    load_use_detect u_lu (
        .ID_EX_memread_i (ID_EX_memread_i),
        .ID_EX_RT_i      (ID_EX_RT_i),
        .ID_RS_i         (ID_RS_i),
        .ID_RT_i         (ID_RT_i),
        .hazard_o        (w_lu)
    );

    // Load-use wins over a branch: the branch compared a stale operand.
    assign w_resolve = w_lu ? CTRL_LU : branch_taken_i ? CTRL_FLUSH : CTRL_IDLE;
    assign w_freeze  = (r_state == ERR) ||
                       ((r_state == MEM_WAIT) ? !mem_ack_i : (mem_req_i && !mem_ack_i));
    assign w_ctrl    = rst_i ? CTRL_IDLE : w_freeze ? CTRL_FREEZE : w_resolve;
    // r_wcnt holds completed waits, so the current cycle is wait number r_wcnt+1.
    assign w_tmo     = (TIMEOUT != 0) && (r_wcnt == WC_W'(TIMEOUT - 1));

    assign PC_write_o      = w_ctrl.pc_write;
    assign IF_ID_write_o   = w_ctrl.if_id_write;
    assign IF_flush_o      = w_ctrl.if_flush;
    assign ID_EX_write_o   = w_ctrl.id_ex_write;
    assign ID_EX_bubble_o  = w_ctrl.id_ex_bubble;
    assign EX_MEM_write_o  = w_ctrl.ex_mem_write;
    assign MEM_WB_bubble_o = w_ctrl.mem_wb_bubble;
    assign mem_err_o       = (r_state == ERR);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_wcnt  <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (mem_req_i && !mem_ack_i) begin
                        r_state <= MEM_WAIT;
                        r_wcnt  <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack_i) begin
                        r_state <= RUN;
                        r_wcnt  <= '0;
                    end else if (w_tmo) begin
                        r_state <= ERR;
                    end else begin
                        r_wcnt  <= r_wcnt + WC_W'(1);
                    end
                end
                default: r_state <= ERR;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flush;

    // Both freeze and load-use hold the PC, so !pc_write marks a stall cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if (!w_ctrl.pc_write && (r_stall != '1))
                r_stall <= r_stall + CNT_W'(1);
            if (w_ctrl.if_flush && (r_flush != '1))
                r_flush <= r_flush + CNT_W'(1);
        end
    end

    assign stall_cycles_o = r_stall;
    assign flush_count_o  = r_flush;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    rs = '0, rt = '0, ex_rt = '0;
    logic          memread = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
    logic          pc_w, ifid_w, if_fl, idex_w, idex_b, exmem_w, mwb_b, merr;
    logic [CW-1:0] stall_c, flush_c;

    typedef struct {
        logic [6:0] ctl;
        logic       err;
        int         stall;
        int         flush;
    } exp_t;

    exp_t q[$];
    int   errs = 0;
    int   checks = 0;

    bit m_err = 0;
    int m_wait = 0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ID_RS_i         (rs),
        .ID_RT_i         (rt),
        .ID_EX_memread_i (memread),
        .ID_EX_RT_i      (ex_rt),
        .branch_taken_i  (br),
        .mem_req_i       (req),
        .mem_ack_i       (ack),
        .PC_write_o      (pc_w),
        .IF_ID_write_o   (ifid_w),
        .IF_flush_o      (if_fl),
        .ID_EX_write_o   (idex_w),
        .ID_EX_bubble_o  (idex_b),
        .EX_MEM_write_o  (exmem_w),
        .MEM_WB_bubble_o (mwb_b),
        .mem_err_o       (merr),
        .stall_cycles_o  (stall_c),
        .flush_count_o   (flush_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset cycles raise rst just after an edge and drop it mid low phase,
    // with all inputs quiet so the following edge sees an idle pipeline.
    task automatic step(input bit r, input bit mr, input int ert, input int s, input int t,
                        input bit b, input bit rq, input bit ak);
        exp_t e;
        bit   lu, frz, stalled, flushed;
        @(posedge clk);
        #1;
        rst = r; memread = mr; ex_rt = 5'(ert); rs = 5'(s); rt = 5'(t);
        br = b; req = rq; ack = ak;
        if (r) begin
            m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
            e.ctl = 7'b1101010; e.err = 0; e.stall = 0; e.flush = 0;
            q.push_back(e);
            @(negedge clk);
            #2;
            rst = 0; memread = 0; br = 0; req = 0; ack = 0;
        end else begin
            lu  = mr && (ert != 0) && (ert == s || ert == t);
            frz = m_err || ((m_wait > 0) ? !ak : (rq && !ak));
            stalled = frz || lu;
            flushed = !frz && !lu && b;
            if (frz)     e.ctl = 7'b0000001;
            else if (lu) e.ctl = 7'b0001110;
            else if (b)  e.ctl = 7'b1111010;
            else         e.ctl = 7'b1101010;
            e.err = m_err;
`ifdef HAZARD_PERF_CNT_EN
            e.stall = m_stall;
            e.flush = m_flush;
`else
            e.stall = 0;
            e.flush = 0;
`endif
            q.push_back(e);
            if (!m_err) begin
                if (frz) begin
                    m_wait++;
                    if (m_wait == TO) m_err = 1;
                end else begin
                    m_wait = 0;
                end
            end
            if (stalled && m_stall < CMAX) m_stall++;
            if (flushed && m_flush < CMAX) m_flush++;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ctrl", {25'd0, pc_w, ifid_w, if_fl, idex_w, idex_b, exmem_w, mwb_b}, {25'd0, e.ctl});
                chk("mem_err", {31'd0, merr}, {31'd0, e.err});
                chk("stall_cycles", {28'd0, stall_c}, 32'(e.stall));
                chk("flush_count", {28'd0, flush_c}, 32'(e.flush));
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs, then clear; r0 destination never stalls
        step(0, 1, 8, 8, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // branch suppressed by load-use on rt, then taken
        step(0, 1, 9, 1, 9, 1, 0, 0);
        step(0, 0, 0, 1, 9, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // three-cycle memory wait, branch held during freeze
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // request acked in the same cycle
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // watchdog: four waits, then sticky error
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, i[0], 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 8, 8, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // reset pulsed mid-cycle while waiting with two waits completed
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // randomized traffic, long enough to saturate the counters
        for (int i = 0; i < 2000; i++)
            step($urandom_range(99) < 3, 1'($urandom), $urandom_range(3), $urandom_range(3),
                 $urandom_range(3), $urandom_range(3) == 0, $urandom_range(9) < 3, 1'($urandom));
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
